// File: rtl/fir_out_buffer.sv
// fir_out_buffer: output stage for the precomputation FIR filter.
// Takes the unsigned (4N+1)-bit filter result, scales it to OUT_W bits with
// a round-half-up right shift plus saturation, registers it, and queues it
// in a DEPTH-entry first-word-fall-through FIFO drained over valid/ready.
// Samples that arrive while the FIFO is full and not being read are dropped
// and flagged on a sticky overflow bit.
module fir_out_buffer #(
  parameter int N     = 4,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4*N:0]             in_data,
  input  logic                     in_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int IW = 4*N + 1;
  localparam int SW = IW + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Rounding constant and saturation limit, both at the widened sum width
  // so the add can never wrap.
  localparam logic [SW-1:0] RND  = SW'(1) << (SHIFT - 1);
  localparam logic [SW-1:0] MAXQ = SW'((1 << OUT_W) - 1);

  logic [SW-1:0]    sum;
  logic [SW-1:0]    q_shift;

  logic [OUT_W-1:0] s_data_d,   s_data_q;
  logic             s_valid_d,  s_valid_q;
  logic [AW-1:0]    wr_ptr_d,   wr_ptr_q;
  logic [AW-1:0]    rd_ptr_d,   rd_ptr_q;
  logic [LW-1:0]    level_d,    level_q;
  logic             overflow_d, overflow_q;
  logic [OUT_W-1:0] out_data_d, out_data_q;

  logic [OUT_W-1:0] mem_q [DEPTH];

  logic full;
  logic do_read;
  logic do_write;
  logic drop;

  // Scaling: round half up, shift, clamp to the largest OUT_W-bit value.
  always_comb begin
    sum       = {1'b0, in_data} + RND;
    q_shift   = sum >> SHIFT;
    s_data_d  = (q_shift > MAXQ) ? {OUT_W{1'b1}} : q_shift[OUT_W-1:0];
    s_valid_d = in_valid;
  end

  // FIFO control: handshake, write/drop decision, pointer/level/flag updates
  // and the next head value.
  always_comb begin
    full       = (level_q == LW'(DEPTH));
    do_read    = (level_q != '0) && out_ready;
    // A full FIFO still accepts a write when the head pops on the same edge.
    do_write   = s_valid_q && (!full || do_read);
    drop       = s_valid_q && full && !do_read;

    wr_ptr_d   = do_write ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = do_read  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(do_write) - LW'(do_read);
    // A drop on the same edge as a clear keeps the flag set.
    overflow_d = drop | (overflow_q & ~clr_ovf);

    // out_data is kept in a register that always holds the head. When the
    // entry being written lands exactly at the new read pointer it becomes
    // the head on this edge, so it is bypassed around the memory.
    out_data_d = out_data_q;
    if (level_d != '0) begin
      if (do_write && (wr_ptr_q == rd_ptr_d)) begin
        out_data_d = s_data_q;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Control state with asynchronous clear; an in-flight scaled sample is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_data_q   <= '0;
      s_valid_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      s_data_q   <= s_data_d;
      s_valid_q  <= s_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
    end
  end

  // Sample storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= s_data_q;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = (level_q != '0);
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Testbench for fir_out_buffer: table of rounding vectors, hand sequences
// for fill/overflow/clear/reset, and random traffic against a queue model.
module tb_fir_out_buffer;

  localparam int N     = 4;
  localparam int OUT_W = 8;
  localparam int SHIFT = 4;
  localparam int DEPTH = 8;

  logic          clk;
  logic          reset;
  logic [16:0]   in_data;
  logic          in_valid;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    level;
  logic          overflow;
  logic          clr_ovf;

  fir_out_buffer #(.N(N), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of scaled samples plus the one-stage pipe.
  int mq[$];
  int m_s_valid;
  int m_s_data;
  int m_ovf;
  int m_held;

  typedef struct {
    int din;
    int dout;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int scale(input int d);
    int r;
    r = (d + 2**(SHIFT-1)) / (2**SHIFT);
    if (r > 2**OUT_W - 1) r = 2**OUT_W - 1;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_s_valid = 0;
    m_s_data  = 0;
    m_ovf     = 0;
    m_held    = 0;
  endtask

  task automatic model_edge(input bit iv, input int d, input bit rdy, input bit clr);
    bit rd;
    bit drp;
    rd  = (mq.size() > 0) && rdy;
    drp = 1'b0;
    if (rd) void'(mq.pop_front());
    if (m_s_valid != 0) begin
      if (mq.size() < DEPTH) mq.push_back(m_s_data);
      else drp = 1'b1;
    end
    if (drp) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_s_valid = iv ? 1 : 0;
    m_s_data  = scale(d);
    if (mq.size() > 0) m_held = mq[0];
  endtask

  task automatic compare_model();
    check("m_out_valid", out_valid, (mq.size() > 0) ? 1 : 0);
    check("m_level", level, mq.size());
    check("m_overflow", overflow, m_ovf);
    if (mq.size() > 0) check("m_out_data", out_data, m_held);
  endtask

  // Drive inputs, take one edge, advance the model, compare 1 ns later.
  task automatic cycle(input bit iv, input int d, input bit rdy, input bit clr);
    in_valid  = iv;
    in_data   = 17'(d);
    out_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);
    model_edge(iv, d, rdy, clr);
    #1;
    compare_model();
  endtask

  initial begin
    vt[0] = '{40, 3};
    vt[1] = '{48, 3};
    vt[2] = '{4071, 254};
    vt[3] = '{4087, 255};
    vt[4] = '{4088, 255};
    vt[5] = '{131071, 255};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;

    // Rounding and saturation, one isolated sample at a time.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, vt[i].din, 1'b1, 1'b0);
      check("rnd_valid_e0", out_valid, 0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      check("rnd_valid_e1", out_valid, 1);
      check("rnd_data", out_data, vt[i].dout);
      cycle(1'b0, 0, 1'b1, 1'b0);
      check("rnd_valid_e2", out_valid, 0);
    end

    // Fill under back-pressure; 9th and 10th samples are dropped.
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, 16*k, 1'b0, 1'b0);
      if (k == 9) check("fill_ovf_before_drop", overflow, 0);
      if (k == 10) check("fill_ovf_after_9th", overflow, 1);
    end
    cycle(1'b0, 0, 1'b0, 1'b0);
    check("fill_level", level, 8);
    check("fill_overflow", overflow, 1);
    for (int k = 1; k <= 8; k++) begin
      check("drain_data", out_data, k);
      cycle(1'b0, 0, 1'b1, 1'b0);
    end
    check("drain_level", level, 0);
    check("drain_ovf_sticky", overflow, 1);

    // Clear on the same edge as a drop: set wins.
    for (int k = 1; k <= 9; k++) cycle(1'b1, 16*(k+10), 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("clr_vs_drop", overflow, 1);
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("clr_no_drop", overflow, 0);

    // Full FIFO, write and read on the same edge.
    cycle(1'b1, 16*30, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    check("simul_level", level, 8);
    check("simul_overflow", overflow, 0);
    for (int k = 0; k < 8; k++) begin
      check("simul_order", out_data, (k < 7) ? 12 + k : 30);
      cycle(1'b0, 0, 1'b1, 1'b0);
    end
    check("simul_empty", level, 0);

    // Random traffic with alternating back-pressure phases.
    for (int c = 0; c < 3000; c++) begin
      int sel;
      int d;
      bit iv;
      bit rdy;
      bit clr;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       d = $urandom_range(0, 131071);
        1:       d = $urandom_range(4070, 4100);
        2:       d = $urandom_range(0, 64);
        default: d = 131071 - $urandom_range(0, 40);
      endcase
      iv  = ($urandom_range(0, 3) != 0);
      if (((c / 200) % 2) == 0) rdy = ($urandom_range(0, 3) != 0);
      else rdy = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 30) == 0);
      cycle(iv, d, rdy, clr);
    end

    // Reset in the middle of operation.
    for (int i = 0; i < 20; i++) cycle(1'b0, 0, 1'b1, 1'b1);
    check("pre_rst_empty", level, 0);
    for (int k = 1; k <= 6; k++) cycle(1'b1, 16*k, 1'b0, 1'b0);
    check("pre_rst_level", level, 5);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_level", level, 0);
    check("async_rst_overflow", overflow, 0);
    check("async_rst_out_data", out_data, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b1, 16*7, 1'b1, 1'b0);
    check("post_rst_e0_valid", out_valid, 0);
    check("post_rst_e0_level", level, 0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    check("post_rst_e1_valid", out_valid, 1);
    check("post_rst_e1_data", out_data, 7);
    check("post_rst_e1_level", level, 1);
    cycle(1'b0, 0, 1'b1, 1'b0);
    check("post_rst_e2_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
